fetch_unit: RTL

Parametrised instruction-fetch / program-counter unit for the CPU front end. It generalises the PC register to a configurable address width and a configurable sign-extended, scaled relative-branch offset. It adds absolute jumps and a hardware return-address stack (RAS) for call/return. It drives the instruction-memory address every cycle and takes its control from the decoder.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/ret_stack.sv | 66 ++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: parameter defaults and
// the resolved per-cycle command produced by the priority encoder.
package fetch_pkg;

    localparam int unsigned PC_W_DEF      = 8;
    localparam int unsigned TGT_W_DEF     = 3;
    localparam int unsigned TGT_SHIFT_DEF = 2;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    // One command wins each cycle; listed in decreasing priority.
    typedef enum logic [2:0] {
        CMD_HOLD   = 3'd0,
        CMD_RET    = 3'd1,
        CMD_CALL   = 3'd2,
        CMD_JUMP   = 3'd3,
        CMD_BRANCH = 3'd4,
        CMD_SEQ    = 3'd5
    } cmd_e;

endpackage : fetch_pkg

// File: rtl/ret_stack.sv
// Circular LIFO return-address stack.
// Ports:
//   clk, rst_n      - clock, async active-low reset (clears pointer and count)
//   push, push_data - write push_data on top; when full the oldest entry is overwritten
//   pop             - discard top entry; no-op when empty
//   top_data_c      - current top entry (combinational read of stored data)
//   count           - number of valid entries (registered)
//   full_c, empty_c - decoded from count
// push has priority if both are asserted; the caller never does that.
module ret_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top_data_c,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full_c,
    output logic                           empty_c
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;      // next slot to write; top entry is one below
    logic [PTR_W-1:0] top_idx_c;
    logic [PTR_W-1:0] nxt_ptr_c;

    // Pointer arithmetic modulo DEPTH (DEPTH need not be a power of two).
    always_comb begin
        top_idx_c = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);
        nxt_ptr_c = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end

    assign full_c     = (count == CNT_W'(DEPTH));
    assign empty_c    = (count == '0);
    assign top_data_c = mem[top_idx_c];

    // Pointer and occupancy; a full push wraps onto the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= nxt_ptr_c;
            if (!full_c) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty_c) begin
            wr_ptr <= top_idx_c;
            count  <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule : ret_stack

// File: rtl/fetch_unit.sv
// Instruction-fetch / program-counter unit with relative branch, absolute
// jump and a hardware return-address stack for call/return.
// Ports:
//   CLK, Init_n           - clock, async active-low reset
//   Stall                 - freeze PC, stack and flags for this cycle
//   Branch, Target        - PC += sign-extended Target << TGT_SHIFT
//   Jump, JumpAddr        - PC = JumpAddr
//   Call                  - push PC+1, PC = JumpAddr
//   Ret                   - pop into PC (PC+1 and underflow flag if empty)
//   PC                    - current fetch address (registered)
//   RasCount              - valid stack entries (registered)
//   RasOverflow/Underflow - sticky error flags, cleared only by reset
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     TGT_W     = TGT_W_DEF,
    parameter int unsigned     TGT_SHIFT = TGT_SHIFT_DEF,
    parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [PC_W-1:0] START_PC  = '0
) (
    input  logic                               CLK,
    input  logic                               Init_n,
    input  logic                               Stall,
    input  logic                               Branch,
    input  logic [TGT_W-1:0]                   Target,
    input  logic                               Jump,
    input  logic                               Call,
    input  logic                               Ret,
    input  logic [PC_W-1:0]                    JumpAddr,
    output logic [PC_W-1:0]                    PC,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     RasCount,
    output logic                               RasOverflow,
    output logic                               RasUnderflow
);

    // Wide enough for both the sign extension and the final truncation.
    localparam int unsigned EXT_W = (PC_W > TGT_W) ? PC_W : TGT_W;

    cmd_e            cmd_c;
    logic [EXT_W-1:0] tgt_ext_c;
    logic [PC_W-1:0] offset_c;
    logic [PC_W-1:0] pc_inc_c;
    logic [PC_W-1:0] pc_nxt_c;
    logic [PC_W-1:0] ras_top_c;
    logic            ras_full_c;
    logic            ras_empty_c;
    logic            push_c;
    logic            pop_c;
    logic            ovf_set_c;
    logic            unf_set_c;

    assign tgt_ext_c = EXT_W'(signed'(Target));
    assign offset_c  = PC_W'(tgt_ext_c << TGT_SHIFT);
    assign pc_inc_c  = PC + PC_W'(1);

    // Fixed-priority command resolution.
    always_comb begin
        cmd_c = CMD_SEQ;
        if      (Stall)  cmd_c = CMD_HOLD;
        else if (Ret)    cmd_c = CMD_RET;
        else if (Call)   cmd_c = CMD_CALL;
        else if (Jump)   cmd_c = CMD_JUMP;
        else if (Branch) cmd_c = CMD_BRANCH;
    end

    // Next PC, stack control and flag set requests for the resolved command.
    always_comb begin
        pc_nxt_c  = PC;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        ovf_set_c = 1'b0;
        unf_set_c = 1'b0;
        case (cmd_c)
            CMD_HOLD: ;
            CMD_RET: begin
                if (ras_empty_c) begin
                    pc_nxt_c  = pc_inc_c;
                    unf_set_c = 1'b1;
                end else begin
                    pc_nxt_c = ras_top_c;
                    pop_c    = 1'b1;
                end
            end
            CMD_CALL: begin
                pc_nxt_c  = JumpAddr;
                push_c    = 1'b1;
                ovf_set_c = ras_full_c;
            end
            CMD_JUMP:   pc_nxt_c = JumpAddr;
            CMD_BRANCH: pc_nxt_c = PC + offset_c;
            CMD_SEQ:    pc_nxt_c = pc_inc_c;
            default:    pc_nxt_c = pc_inc_c;
        endcase
    end

    // PC and sticky flags.
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            PC           <= START_PC;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else begin
            PC           <= pc_nxt_c;
            RasOverflow  <= RasOverflow  | ovf_set_c;
            RasUnderflow <= RasUnderflow | unf_set_c;
        end
    end

    ret_stack #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .clk        (CLK),
        .rst_n      (Init_n),
        .push       (push_c),
        .pop        (pop_c),
        .push_data  (pc_inc_c),
        .top_data_c (ras_top_c),
        .count      (RasCount),
        .full_c     (ras_full_c),
        .empty_c    (ras_empty_c)
    );

endmodule : fetch_unit
